// File: rtl/multiplexor_display.sv
// rtl/multiplexor_display.sv - four-digit time-multiplexed hex display scanner
//
// Ports:
//   reloj        in   system clock, rising edge
//   reinicio_n   in   asynchronous active-low reset
//   valor[15:0]  in   four hex nibbles, digit i = valor[4i+3:4i]
//   cargar       in   load strobe, valor captured on every edge it is high
//   apagar_ceros in   1 = blank leading-zero digits (digit 0 always lit)
//   digito[3:0]  out  nibble of the selected digit, feeds the 7-segment translator
//   anodo[3:0]   out  active-low digit enables, one cycle behind digito
//   fin_barrido  out  one-cycle pulse after each completed 4-digit scan

module multiplexor_display #(
    parameter int DIVISOR = 50000
) (
    input  logic        reloj,
    input  logic        reinicio_n,
    input  logic [15:0] valor,
    input  logic        cargar,
    input  logic        apagar_ceros,
    output logic [3:0]  digito,
    output logic [3:0]  anodo,
    output logic        fin_barrido
);

    localparam logic [15:0] CNT_LAST = 16'(DIVISOR - 1);

    logic [15:0] cnt_q,       cnt_d;
    logic [1:0]  indice_q,    indice_d;
    logic [15:0] pendiente_q, pendiente_d;
    logic [15:0] mostrado_q,  mostrado_d;
    logic [3:0]  digito_q,    digito_d;
    logic        blank_q,     blank_d;
    logic [3:0]  anodo_q,     anodo_d;
    logic        fin_q,       fin_d;

    logic tick;
    logic wrap;
    logic leading_zero;

    always_comb begin
        tick = (cnt_q == CNT_LAST);
        wrap = tick && (indice_q == 2'd3);

        cnt_d    = tick ? 16'd0 : cnt_q + 16'd1;
        indice_d = tick ? indice_q + 2'd1 : indice_q;

        pendiente_d = cargar ? valor : pendiente_q;

        // A load on the wrap edge itself bypasses pendiente so the new value
        // is shown starting with digit 0 of the scan that begins now.
        mostrado_d = mostrado_q;
        if (wrap) begin
            mostrado_d = cargar ? valor : pendiente_q;
        end

        // Leading-zero test against the value that will be on screen for the
        // digit being selected; digit 0 is never considered blank.
        leading_zero = 1'b0;
        case (indice_d)
            2'd1:    leading_zero = (mostrado_d[15:4]  == 12'h000);
            2'd2:    leading_zero = (mostrado_d[15:8]  == 8'h00);
            2'd3:    leading_zero = (mostrado_d[15:12] == 4'h0);
            default: leading_zero = 1'b0;
        endcase

        // digito and its blank flag are captured together so the anode stage
        // one cycle later uses the conditions of the digit it is enabling.
        digito_d = digito_q;
        blank_d  = blank_q;
        if (tick) begin
            digito_d = mostrado_d[{indice_d, 2'b00} +: 4];
            blank_d  = apagar_ceros && leading_zero;
        end

        // indice_q names the digit currently held in digito_q, so decoding it
        // here delays the anode by exactly the translator's one-cycle latency.
        anodo_d = blank_q ? 4'b1111 : ~(4'b0001 << indice_q);

        fin_d = wrap;
    end

    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            cnt_q       <= 16'd0;
            indice_q    <= 2'd0;
            pendiente_q <= 16'h0000;
            mostrado_q  <= 16'h0000;
            digito_q    <= 4'h0;
            blank_q     <= 1'b0;
            anodo_q     <= 4'b1111;
            fin_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            indice_q    <= indice_d;
            pendiente_q <= pendiente_d;
            mostrado_q  <= mostrado_d;
            digito_q    <= digito_d;
            blank_q     <= blank_d;
            anodo_q     <= anodo_d;
            fin_q       <= fin_d;
        end
    end

    assign digito      = digito_q;
    assign anodo       = anodo_q;
    assign fin_barrido = fin_q;

endmodule
